xbar_slave_bridge: RTL

Registered bridge between one crossbar slave port and the slave device behind it. It captures a held request from the crossbar, re-issues it to the slave, and returns the slave's read data to the crossbar as a one-cycle acknowledge. An optional watchdog ends any access the slave never acknowledges, so a dead slave cannot stall a crossbar master indefinitely. One instance sits on each of the SLAVE_N crossbar outputs, in the crossbar clock domain.

---
 rtl/xbar_slave_bridge.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/xbar_slave_bridge.sv
// -----------------------------------------------------------------------------
// xbar_slave_bridge
//
// Registered bridge between one crossbar slave port and the slave device
// behind it. A held crossbar request is captured once, re-issued to the slave
// on dn_*, and the slave's read data comes back to the crossbar as a
// one-cycle up_ack. After the acknowledge, the bridge waits for the crossbar
// to drop its request, so a still-held request is never accepted twice.
//
// Optional feature (compile-time macro BRIDGE_TIMEOUT_EN):
//   defined   - a watchdog ends any access that the slave does not acknowledge
//               within TIMEOUT dn_req-high cycles. The access returns ERR_DATA,
//               timeout pulses for one cycle and err_sticky is set.
//   undefined - there is no counter and ISSUE waits for dn_ack forever.
//               timeout and err_sticky are tied to 0 and err_clr is ignored.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  maximum dn_req-high cycles without dn_ack (>= 1)
//   ERR_DATA up_rdata value returned on a timed-out access
//
// Ports:
//   clk        single clock, rising edge
//   aresetn    asynchronous reset, active HIGH (1 = in reset)
//   up_req     crossbar request, held until up_ack
//   up_addr    request address
//   up_cmd     1 = write, 0 = read
//   up_wdata   write data
//   up_ack     one-cycle completion pulse to the crossbar
//   up_rdata   read data, valid while up_ack = 1
//   dn_req     request to the slave
//   dn_addr    registered address, stable while dn_req = 1
//   dn_cmd     registered command, stable while dn_req = 1
//   dn_wdata   registered write data, stable while dn_req = 1
//   dn_ack     slave completion pulse
//   dn_rdata   slave read data, valid with dn_ack
//   timeout    one-cycle pulse when the watchdog fires
//   err_sticky set by timeout, cleared by err_clr (set wins)
//   err_clr    clears err_sticky
// -----------------------------------------------------------------------------
module xbar_slave_bridge #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_DEAD)
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              up_req,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic              up_cmd,
  input  logic [DATA_W-1:0] up_wdata,
  output logic              up_ack,
  output logic [DATA_W-1:0] up_rdata,
  output logic              dn_req,
  output logic [ADDR_W-1:0] dn_addr,
  output logic              dn_cmd,
  output logic [DATA_W-1:0] dn_wdata,
  input  logic              dn_ack,
  input  logic [DATA_W-1:0] dn_rdata,
  output logic              timeout,
  output logic              err_sticky,
  input  logic              err_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DROP} state_t;

  state_t            state_q, state_d;
  logic              up_ack_d;
  logic [DATA_W-1:0] up_rdata_d;
  logic              dn_req_d;
  logic [ADDR_W-1:0] dn_addr_d;
  logic              dn_cmd_d;
  logic [DATA_W-1:0] dn_wdata_d;
  logic              to_fire;    // watchdog expires on the coming edge

`ifdef BRIDGE_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter holds the number of completed dn_req-high cycles, so it
  // reaches TIMEOUT on the edge that ends the TIMEOUT-th one. A dn_ack on
  // that same edge takes priority and suppresses the timeout.
  assign to_fire = (state_q == ISSUE) && !dn_ack && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && up_req) begin
      cnt_d = '0;
    end else if (state_q == ISSUE && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;           // saturates, never wraps
    end
  end

  always_ff @(posedge clk or posedge aresetn) begin
    if (aresetn) begin
      cnt_q      <= '0;
      timeout    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      timeout    <= to_fire;
      // Set has priority over a simultaneous clear.
      err_sticky <= to_fire | (err_sticky & ~err_clr);
    end
  end
`else
  logic unused_cfg;

  assign to_fire    = 1'b0;
  assign timeout    = 1'b0;
  assign err_sticky = 1'b0;
  assign unused_cfg = err_clr ^ (^ERR_DATA) ^ (TIMEOUT != 0);
`endif

  // Next-state and next-output logic. Every output is a register, so the
  // values computed here appear on the ports one edge later.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    up_ack_d   = 1'b0;
    up_rdata_d = up_rdata;
    dn_req_d   = dn_req;
    dn_addr_d  = dn_addr;
    dn_cmd_d   = dn_cmd;
    dn_wdata_d = dn_wdata;

    case (state_q)
      IDLE: begin
        if (up_req) begin
          dn_addr_d  = up_addr;
          dn_cmd_d   = up_cmd;
          dn_wdata_d = up_wdata;
          dn_req_d   = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (dn_ack) begin
          up_rdata_d = dn_rdata;      // returned for writes as well
          dn_req_d   = 1'b0;
          up_ack_d   = 1'b1;
          state_d    = RESP;
        end else if (to_fire) begin
          up_rdata_d = ERR_DATA;
          dn_req_d   = 1'b0;
          up_ack_d   = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        state_d = DROP;               // up_ack is high for this one cycle
      end
      DROP: begin
        // The crossbar still holds the finished request; wait for it to go.
        if (!up_req) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: every register, data path included, has a reset value so an
  // access interrupted by reset leaves no stale request or data behind.
  always_ff @(posedge clk or posedge aresetn) begin
    if (aresetn) begin
      state_q  <= IDLE;
      up_ack   <= 1'b0;
      up_rdata <= '0;
      dn_req   <= 1'b0;
      dn_addr  <= '0;
      dn_cmd   <= 1'b0;
      dn_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together
      // from the values present before the edge.
      state_q  <= state_d;
      up_ack   <= up_ack_d;
      up_rdata <= up_rdata_d;
      dn_req   <= dn_req_d;
      dn_addr  <= dn_addr_d;
      dn_cmd   <= dn_cmd_d;
      dn_wdata <= dn_wdata_d;
    end
  end

endmodule
